// File: rtl/uart_alu_frame_ctrl.sv
// Framing controller between UART RX/TX byte engines and a combinational ALU: collects
// multi-byte operands A/B plus an opcode byte, latches the ALU result and returns it LSB-first.
module uart_alu_frame_ctrl #(
    parameter int unsigned OP_W        = 8,
    parameter int unsigned OPC_W       = 6,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [7:0]       rx_data_i,
    input  logic             rx_done_i,
    input  logic             tx_done_i,
    input  logic [OP_W-1:0]  alu_result_i,
    output logic [7:0]       tx_data_o,
    output logic             tx_start_o,
    output logic [OP_W-1:0]  a_o,
    output logic [OP_W-1:0]  b_o,
    output logic [OPC_W-1:0] opcode_o,
    output logic             busy_o,
    output logic             frame_err_o
);

    localparam int unsigned NumBytes = OP_W / 8;
    localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
    localparam int unsigned TmoW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [2:0] {StRxA, StRxB, StRxOp, StCalc, StTxSend, StTxWait} state_e;

    state_e                    state_q, state_d;
    logic [IdxW-1:0]           idx_q, idx_d, idx_inc;
    logic [TmoW-1:0]           tmo_q, tmo_d;
    logic [NumBytes-1:0][7:0]  sh_a_q, sh_a_d, sh_b_q, sh_b_d, res_q, res_d;
    logic [OP_W-1:0]           a_q, a_d, b_q, b_d;
    logic [OPC_W-1:0]          opc_q, opc_d;
    logic [7:0]                tx_data_q, tx_data_d;
    logic                      partial, expire;

    assign idx_inc = idx_q + IdxW'(1);

    // A frame is partial once any byte of it has been accepted.
    assign partial = ((state_q == StRxA) && (idx_q != '0)) || (state_q == StRxB) ||
                     (state_q == StRxOp);
    assign expire  = (TIMEOUT_CYC != 0) && partial && !rx_done_i && (tmo_q == TmoLast);

    always_comb begin
        tmo_d = tmo_q + TmoW'(1);
        if (!partial || rx_done_i || expire || (TIMEOUT_CYC == 0)) begin
            tmo_d = '0;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sh_a_d    = sh_a_q;
        sh_b_d    = sh_b_q;
        a_d       = a_q;
        b_d       = b_q;
        opc_d     = opc_q;
        res_d     = res_q;
        tx_data_d = tx_data_q;
        if (expire) begin
            state_d = StRxA;
            idx_d   = '0;
            sh_a_d  = '0;
            sh_b_d  = '0;
        end else begin
            unique case (state_q)
                StRxA: begin
                    if (rx_done_i) begin
                        sh_a_d[idx_q] = rx_data_i;
                        if (idx_q == LastIdx) begin
                            idx_d   = '0;
                            state_d = StRxB;
                        end else begin
                            idx_d = idx_inc;
                        end
                    end
                end
                StRxB: begin
                    if (rx_done_i) begin
                        sh_b_d[idx_q] = rx_data_i;
                        if (idx_q == LastIdx) begin
                            idx_d   = '0;
                            state_d = StRxOp;
                        end else begin
                            idx_d = idx_inc;
                        end
                    end
                end
                StRxOp: begin
                    if (rx_done_i) begin
                        a_d     = sh_a_q;
                        b_d     = sh_b_q;
                        opc_d   = rx_data_i[OPC_W-1:0];
                        state_d = StCalc;
                    end
                end
                StCalc: begin
                    res_d     = alu_result_i;
                    tx_data_d = alu_result_i[7:0];
                    idx_d     = '0;
                    state_d   = StTxSend;
                end
                StTxSend: state_d = StTxWait;
                StTxWait: begin
                    if (tx_done_i) begin
                        if (idx_q == LastIdx) begin
                            idx_d   = '0;
                            state_d = StRxA;
                        end else begin
                            idx_d     = idx_inc;
                            tx_data_d = res_q[idx_inc];
                            state_d   = StTxSend;
                        end
                    end
                end
                default: state_d = StRxA;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StRxA;
            idx_q     <= '0;
            tmo_q     <= '0;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            res_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opc_q     <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            sh_a_q    <= sh_a_d;
            sh_b_q    <= sh_b_d;
            res_q     <= res_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opc_q     <= opc_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign opcode_o    = opc_q;
    assign tx_data_o   = tx_data_q;
    assign tx_start_o  = (state_q == StTxSend);
    assign busy_o      = (state_q == StCalc) || (state_q == StTxSend) || (state_q == StTxWait);
    assign frame_err_o = expire;

endmodule
